// File: rtl/uart_pin_bridge.sv
// Purpose : pad-side UART bridge; registers TX toward the pin and synchronises, glitch-filters
//           and break-detects each RX pin before it reaches the internal UART core.
// Latency : TX 1 cycle; RX SYNC_STAGES+FILT_CYC cycles; break_o after BREAK_CYC filtered-low cycles.
// Backpr. : none; a free-running per-cycle pin path with no handshake.
//
// Ports:
//   clock       system clock, all logic on its rising edge
//   reset       synchronous active-high reset (lines return to idle-high)
//   tx_v7_i     TX lines from the internal UART cores       [N_CH]
//   tx_o        registered TX lines to the pins              [N_CH]
//   rx_i        RX pin inputs, asynchronous to clock         [N_CH]
//   rx_v7_o     synchronised and filtered RX lines to cores  [N_CH]
//   break_o     per-channel line-break flag                  [N_CH]
//   loopback_i  per-channel loopback enable                  [N_CH]
//               (present only when UART_PIN_BRIDGE_LOOPBACK_EN is defined)
module uart_pin_bridge #(
   parameter int N_CH        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 3,
   parameter int BREAK_CYC   = 1024
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] tx_v7_i,
   output logic [N_CH-1:0] rx_v7_o,
   output logic [N_CH-1:0] tx_o,
   input  logic [N_CH-1:0] rx_i,
   output logic [N_CH-1:0] break_o
`ifdef UART_PIN_BRIDGE_LOOPBACK_EN
   ,
   input  logic [N_CH-1:0] loopback_i
`endif
);

   localparam int FW = $clog2(FILT_CYC + 1);
   localparam int BW = $clog2(BREAK_CYC + 1);

   localparam logic [FW-1:0] FC_LAST = FW'(FILT_CYC - 1);
   localparam logic [FW-1:0] FC_ONE  = FW'(1);
   localparam logic [BW-1:0] BC_MAX  = BW'(BREAK_CYC);
   // break_o is set on the same edge that bc lands on BREAK_CYC, so it
   // rises exactly BREAK_CYC cycles after the filtered line falls.
   localparam logic [BW-1:0] BC_SET  = BW'(BREAK_CYC - 1);
   localparam logic [BW-1:0] BC_ONE  = BW'(1);

   // ------------------------------------------------------------------
   // Source selection for the synchroniser and the TX pin
   // ------------------------------------------------------------------
   logic [N_CH-1:0] sync_in;
   logic [N_CH-1:0] tx_d;

`ifdef UART_PIN_BRIDGE_LOOPBACK_EN
   // Loopback feeds the core's own TX through the full RX path so timing
   // matches the pin path, and parks the TX pin at idle.
   always_comb begin
      sync_in = (loopback_i & tx_v7_i) | (~loopback_i & rx_i);
      tx_d    = tx_v7_i | loopback_i;
   end
`else
   always_comb begin
      sync_in = rx_i;
      tx_d    = tx_v7_i;
   end
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [N_CH-1:0] tx_q;
   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] filt_q, filt_d;
   logic [N_CH-1:0] brk_q,  brk_d;
   logic [FW-1:0]   fc_q   [N_CH];
   logic [FW-1:0]   fc_d   [N_CH];
   logic [BW-1:0]   bc_q   [N_CH];
   logic [BW-1:0]   bc_d   [N_CH];

   logic [N_CH-1:0] sync_last;
   assign sync_last = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Glitch filter and break detector next-state
   // Both read the pre-edge filtered level filt_q, so a level change and
   // a break-counter update in the same cycle never see each other.
   // ------------------------------------------------------------------
   always_comb begin
      filt_d = filt_q;
      brk_d  = brk_q;
      fc_d   = fc_q;
      bc_d   = bc_q;
      for (int k = 0; k < N_CH; k++) begin
         // Filter: a new level must persist FILT_CYC consecutive cycles;
         // any return to the current level restarts the count.
         if (sync_last[k] == filt_q[k]) begin
            fc_d[k] = '0;
         end else if (fc_q[k] == FC_LAST) begin
            filt_d[k] = sync_last[k];
            fc_d[k]   = '0;
         end else begin
            fc_d[k] = fc_q[k] + FC_ONE;
         end

         // Break: count filtered-low cycles, saturating at BREAK_CYC.
         if (filt_q[k]) begin
            bc_d[k]  = '0;
            brk_d[k] = 1'b0;
         end else begin
            if (bc_q[k] < BC_MAX) begin
               bc_d[k] = bc_q[k] + BC_ONE;
            end
            if (bc_q[k] >= BC_SET) begin
               brk_d[k] = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers; reset returns every line to idle-high and clears counters
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_q   <= '1;
         filt_q <= '1;
         brk_q  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '1;
         end
         for (int k = 0; k < N_CH; k++) begin
            fc_q[k] <= '0;
            bc_q[k] <= '0;
         end
      end else begin
         tx_q      <= tx_d;
         filt_q    <= filt_d;
         brk_q     <= brk_d;
         // Plain flop chain: no logic between stages.
         sync_q[0] <= sync_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         for (int k = 0; k < N_CH; k++) begin
            fc_q[k] <= fc_d[k];
            bc_q[k] <= bc_d[k];
         end
      end
   end

   assign tx_o    = tx_q;
   assign rx_v7_o = filt_q;
   assign break_o = brk_q;

endmodule

// File: tb/tb_uart_pin_bridge.sv
// Purpose : self-checking bench for uart_pin_bridge at default parameters.
// Latency : bench advances one clock per tick and samples 1 time unit after the edge.
// Backpr. : not applicable; the bench drives pins freely every cycle.
module tb_uart_pin_bridge;

   localparam int N_CH  = 2;
   localparam int SYNC  = 2;
   localparam int FILT  = 3;
   localparam int BREAK = 1024;

   logic            clock = 1'b0;
   logic            reset;
   logic [N_CH-1:0] tx_v7_i;
   logic [N_CH-1:0] rx_v7_o;
   logic [N_CH-1:0] tx_o;
   logic [N_CH-1:0] rx_i;
   logic [N_CH-1:0] break_o;
   logic [N_CH-1:0] lb;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   uart_pin_bridge #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYC(FILT), .BREAK_CYC(BREAK)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tx_v7_i   (tx_v7_i),
      .rx_v7_o   (rx_v7_o),
      .tx_o      (tx_o),
      .rx_i      (rx_i),
      .break_o   (break_o)
`ifdef UART_PIN_BRIDGE_LOOPBACK_EN
      ,
      .loopback_i(lb)
`endif
   );

   // ------------------------------------------------------------------
   // Reference model: delay line for the synchroniser, a history window
   // of the last FILT synchronised samples for the filter, and an
   // unbounded low-run length for break detection.
   // ------------------------------------------------------------------
   logic [SYNC-1:0] m_dl   [N_CH];
   logic [FILT-1:0] m_hist [N_CH];
   logic [N_CH-1:0] m_f, m_brk, m_tx;
   int              m_low  [N_CH];

   task automatic tick();
      logic [N_CH-1:0] src;
      logic sp, fp;
      src = (lb & tx_v7_i) | (~lb & rx_i);
      for (int c = 0; c < N_CH; c++) begin
         if (reset) begin
            m_dl[c]   = '1;
            m_hist[c] = '1;
            m_f[c]    = 1'b1;
            m_brk[c]  = 1'b0;
            m_low[c]  = 0;
            m_tx[c]   = 1'b1;
         end else begin
            sp        = m_dl[c][SYNC-1];
            fp        = m_f[c];
            m_hist[c] = (m_hist[c] << 1) | FILT'(sp);
            if (m_hist[c] == {FILT{~fp}}) m_f[c] = ~fp;
            m_low[c]  = fp ? 0 : m_low[c] + 1;
            m_brk[c]  = !fp && (m_low[c] >= BREAK);
            m_dl[c]   = (m_dl[c] << 1) | SYNC'(src[c]);
            m_tx[c]   = tx_v7_i[c] | lb[c];
         end
      end
      @(posedge clock);
      #1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset   = 1'b1;
      rx_i    = '0;
      tx_v7_i = '0;
      lb      = '0;
      repeat (3) tick();
      checks++; if (tx_o !== 2'b11)    begin errors++; $display("FAIL reset_tx_during got=%b exp=11", tx_o); end
      checks++; if (rx_v7_o !== 2'b11) begin errors++; $display("FAIL reset_rx_during got=%b exp=11", rx_v7_o); end
      checks++; if (break_o !== 2'b00) begin errors++; $display("FAIL reset_brk_during got=%b exp=00", break_o); end
      reset = 1'b0;
      checks++; if (tx_o !== 2'b11 || rx_v7_o !== 2'b11 || break_o !== 2'b00) begin
         errors++; $display("FAIL reset_first_cycle got tx=%b rx=%b brk=%b exp 11/11/00", tx_o, rx_v7_o, break_o);
      end
      // Let the line go idle again before the functional tests.
      rx_i    = '1;
      tx_v7_i = '1;
      repeat (12) tick();
      checks++; if (rx_v7_o !== m_f || break_o !== m_brk || tx_o !== m_tx) begin
         errors++; $display("FAIL reset_settle got rx=%b brk=%b tx=%b exp %b/%b/%b", rx_v7_o, break_o, tx_o, m_f, m_brk, m_tx);
      end
   endtask

   task automatic test_tx();
      tx_v7_i = 2'b11;
      tick();
      tx_v7_i[0] = 1'b0;
      checks++; if (tx_o !== 2'b11) begin errors++; $display("FAIL tx_before_edge got=%b exp=11", tx_o); end
      tick();
      checks++; if (tx_o !== 2'b10) begin errors++; $display("FAIL tx_one_cycle got=%b exp=10", tx_o); end
      tx_v7_i = 2'b01;
      tick();
      checks++; if (tx_o !== 2'b01) begin errors++; $display("FAIL tx_ch1 got=%b exp=01", tx_o); end
      tx_v7_i = '1;
      tick();
   endtask

   task automatic test_filter();
      int n;
      rx_i[1] = 1'b0;
      n = 0;
      while (rx_v7_o[1] !== 1'b0 && n < 20) begin tick(); n++; end
      checks++; if (n != SYNC + FILT) begin errors++; $display("FAIL filt_fall_latency got=%0d exp=%0d", n, SYNC + FILT); end
      checks++; if (rx_v7_o[0] !== 1'b1) begin errors++; $display("FAIL filt_ch0_isolated got=%b exp=1", rx_v7_o[0]); end
      // A 2-cycle high glitch must be swallowed.
      rx_i[1] = 1'b1;
      repeat (2) tick();
      rx_i[1] = 1'b0;
      n = 0;
      repeat (10) begin tick(); if (rx_v7_o[1] !== 1'b0) n++; end
      checks++; if (n != 0) begin errors++; $display("FAIL filt_glitch2 got=%0d high cycles exp=0", n); end
      // A 3-cycle high pulse must pass.
      rx_i[1] = 1'b1;
      n = 0;
      repeat (3) begin tick(); n++; end
      rx_i[1] = 1'b0;
      while (rx_v7_o[1] !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != SYNC + FILT) begin errors++; $display("FAIL filt_pulse3 got=%0d exp=%0d", n, SYNC + FILT); end
      rx_i[1] = 1'b1;
      repeat (12) tick();
      checks++; if (rx_v7_o !== 2'b11) begin errors++; $display("FAIL filt_restore got=%b exp=11", rx_v7_o); end
   endtask

   task automatic test_break();
      int n, t;
      rx_i[0] = 1'b0;
      n = 0;
      while (rx_v7_o[0] !== 1'b0 && n < 20) begin tick(); n++; end
      t = n;
      n = 0;
      while (break_o[0] !== 1'b1 && n < BREAK + 50) begin tick(); n++; end
      t += n;
      checks++; if (n != BREAK) begin errors++; $display("FAIL brk_rise got=%0d exp=%0d", n, BREAK); end
      n = 0;
      while (t < 1100) begin
         tick(); t++;
         if (break_o[0] !== 1'b1 || rx_v7_o[0] !== 1'b0 || break_o[1] !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL brk_hold got=%0d bad cycles exp=0", n); end
      rx_i[0] = 1'b1;
      n = 0;
      while (rx_v7_o[0] !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (break_o[0] !== 1'b1) begin errors++; $display("FAIL brk_at_rise got=%b exp=1", break_o[0]); end
      tick();
      checks++; if (break_o[0] !== 1'b0) begin errors++; $display("FAIL brk_clear got=%b exp=0", break_o[0]); end
      checks++; if (rx_v7_o !== m_f || break_o !== m_brk) begin
         errors++; $display("FAIL brk_model got rx=%b brk=%b exp %b/%b", rx_v7_o, break_o, m_f, m_brk);
      end
   endtask

   task automatic test_reset_break();
      int n;
      rx_i[0] = 1'b0;
      n = 0;
      while (break_o[0] !== 1'b1 && n < 1200) begin tick(); n++; end
      checks++; if (break_o[0] !== 1'b1) begin errors++; $display("FAIL rbrk_setup got=%b exp=1", break_o[0]); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (break_o !== 2'b00 || rx_v7_o !== 2'b11) begin
         errors++; $display("FAIL rbrk_after_reset got brk=%b rx=%b exp 00/11", break_o, rx_v7_o);
      end
      n = 0;
      while (break_o[0] !== 1'b1 && n < 1200) begin tick(); n++; end
      checks++; if (n != SYNC + FILT + BREAK) begin errors++; $display("FAIL rbrk_rearm got=%0d exp=%0d", n, SYNC + FILT + BREAK); end
      rx_i[0] = 1'b1;
      repeat (12) tick();
      checks++; if (break_o !== 2'b00 || rx_v7_o !== 2'b11) begin
         errors++; $display("FAIL rbrk_recover got brk=%b rx=%b exp 00/11", break_o, rx_v7_o);
      end
   endtask

   task automatic test_random();
      int hold, bad;
      hold = 0;
      bad  = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            rx_i = N_CH'($urandom);
            hold = ($urandom_range(0, 40) == 0) ? 1100 : $urandom_range(1, 5);
         end
         hold--;
         tx_v7_i = N_CH'($urandom);
         reset   = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if (rx_v7_o !== m_f || break_o !== m_brk || tx_o !== m_tx) begin
            errors++;
            bad++;
            if (bad <= 20)
               $display("FAIL rand_cycle%0d got rx=%b brk=%b tx=%b exp %b/%b/%b",
                        i, rx_v7_o, break_o, tx_o, m_f, m_brk, m_tx);
         end
      end
      reset   = 1'b0;
      rx_i    = '1;
      tx_v7_i = '1;
      repeat (12) tick();
   endtask

`ifdef UART_PIN_BRIDGE_LOOPBACK_EN
   task automatic test_loopback();
      logic [9:0] frame;
      logic       drv [$];
      int         bad, t;
      frame = {1'b1, 8'h55, 1'b0};
      lb    = 2'b01;
      rx_i  = '1;
      tx_v7_i = '1;
      bad = 0;
      t   = 0;
      for (int c = 0; c < 32 + 10 * 16 + 32; c++) begin
         if (c >= 32 && c < 32 + 160) tx_v7_i[0] = frame[(c - 32) / 16];
         else                         tx_v7_i[0] = 1'b1;
         drv.push_back(tx_v7_i[0]);
         tick();
         t++;
         if (t > SYNC + FILT - 1) begin
            if (rx_v7_o[0] !== drv[t - (SYNC + FILT)]) bad++;
         end
         if (tx_o[0] !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL loopback got=%0d bad cycles exp=0", bad); end
      lb = '0;
      repeat (12) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_tx();
      test_filter();
      test_break();
      test_reset_break();
`ifdef UART_PIN_BRIDGE_LOOPBACK_EN
      test_loopback();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
